// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state encoding and the
// counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StArmPress   = 2'd1,
    StHeld       = 2'd2,
    StArmRelease = 2'd3
  } deb_state_e;

  // Counter must hold values 0..stable_cnt inclusive.
  function automatic int unsigned cnt_w(input int unsigned stable_cnt);
    return (stable_cnt < 1) ? 1 : $clog2(stable_cnt + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: FSM plus stability counter, advanced only on sample ticks.
// Emits a registered level and single-cycle press/release pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW = cnt_w(STABLE_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  deb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + CntOne;
    if (tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (s_i) begin
            if (STABLE_CNT == 1) begin
              state_d = StHeld;
              press_d = 1'b1;
            end else begin
              state_d = StArmPress;
              cnt_d   = CntOne;
            end
          end
        end
        StArmPress: begin
          if (!s_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_inc == CntMax) begin
            state_d = StHeld;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (!s_i) begin
            if (STABLE_CNT == 1) begin
              state_d   = StIdle;
              release_d = 1'b1;
            end else begin
              state_d = StArmRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StArmRelease: begin
          if (s_i) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_inc == CntMax) begin
            state_d   = StIdle;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
    // Level is derived from the next state so it moves together with the state register.
    level_d = (state_d == StHeld) || (state_d == StArmRelease);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel button conditioner: synchronises the slow divider clock into a sample tick,
// synchronises the raw buttons and debounces each channel independently.
module btn_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_BTN       = 5,
  parameter int unsigned STABLE_CNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_clk_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  logic [SYNC_STAGES-1:0]            samp_sync_q;
  logic                              samp_edge_q;
  logic [SYNC_STAGES-1:0][N_BTN-1:0] btn_sync_q;
  logic                              tick;

  // Index 0 is the stage closest to the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_sync_q <= '0;
      samp_edge_q <= 1'b0;
      btn_sync_q  <= '0;
    end else begin
      samp_sync_q <= {samp_sync_q[SYNC_STAGES-2:0], sample_clk_i};
      samp_edge_q <= samp_sync_q[SYNC_STAGES-1];
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end
  end

  assign tick = samp_sync_q[SYNC_STAGES-1] & ~samp_edge_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT(STABLE_CNT)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s_i      (btn_sync_q[SYNC_STAGES-1][g]),
      .tick_i   (tick),
      .level_o  (btn_level_o[g]),
      .press_o  (btn_press_o[g]),
      .release_o(btn_release_o[g])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with default parameters; sample_clk has an 8-clk period.
module tb_btn_debouncer;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_clk = 1'b0;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] btn_level_o, btn_press_o, btn_release_o;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int press_cnt [NB] = '{default: 0};
  int rel_cnt [NB] = '{default: 0};
  logic [NB-1:0] last_press = '0;
  logic [NB-1:0] last_rel = '0;
  int bad_lvl = 0;
  int bad_both = 0;
  int r;

  btn_debouncer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clk_i (sample_clk),
    .btn_raw_i    (btn_raw),
    .btn_level_o  (btn_level_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o)
  );

  always #5 clk = ~clk;

  // Slow strobe with edges deliberately offset from every clk edge.
  initial begin
    #2;
    forever #40 sample_clk = ~sample_clk;
  end

  always @(posedge sample_clk) rise_cnt++;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        if (btn_press_o[i]) press_cnt[i]++;
        if (btn_release_o[i]) rel_cnt[i]++;
        if (btn_press_o[i] && !btn_level_o[i]) bad_lvl++;
        if (btn_release_o[i] && btn_level_o[i]) bad_lvl++;
      end
      if ((btn_press_o & btn_release_o) != '0) bad_both++;
      if (btn_press_o != '0) last_press = btn_press_o;
      if (btn_release_o != '0) last_rel = btn_release_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wait for n sample_clk rises, then long enough for the resulting tick to be consumed.
  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = rise_cnt + n;
    budget = 16 * n + 16;
    while (rise_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (rise_cnt < target) check_eq("tick_timeout", 32'(rise_cnt), 32'(target));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pulse(input int ch, input bit rel, output int rises);
    int  base;
    int  budget;
    bit  seen;
    base   = rise_cnt;
    budget = 100;
    seen   = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge clk);
      budget--;
      seen = rel ? btn_release_o[ch] : btn_press_o[ch];
    end
    if (!seen) check_eq("pulse_timeout", 32'(seen), 32'd1);
    rises = rise_cnt - base;
  endtask

  // Land in the middle of a sample_clk low phase, away from any rising edge.
  task automatic align();
    @(negedge sample_clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with all buttons pressed.
    rst     = 1'b1;
    btn_raw = '1;
    repeat (4) @(negedge clk);
    check_eq("a_rst_level", 32'(btn_level_o), 32'h0);
    check_eq("a_rst_press", 32'(btn_press_o), 32'h0);
    check_eq("a_rst_release", 32'(btn_release_o), 32'h0);
    align();
    rst = 1'b0;
    wait_ticks(3);
    check_eq("a_level_3t", 32'(btn_level_o), 32'h0);
    wait_ticks(1);
    check_eq("a_level_4t", 32'(btn_level_o), 32'h1f);
    check_eq("a_press_vec", 32'(last_press), 32'h1f);
    align();
    btn_raw = '0;
    wait_ticks(5);
    check_eq("a_rel_level", 32'(btn_level_o), 32'h0);
    check_eq("a_rel_vec", 32'(last_rel), 32'h1f);

    // Clean press on channel 0.
    align();
    btn_raw[0] = 1'b1;
    wait_pulse(0, 1'b0, r);
    check_eq("b_latency", 32'(r), 32'd4);
    check_eq("b_level_at_press", 32'(btn_level_o[0]), 32'd1);
    check_eq("b_no_rel", 32'(btn_release_o[0]), 32'd0);
    wait_ticks(2);
    check_eq("b_press_cnt", 32'(press_cnt[0]), 32'd2);
    check_eq("b_rel_cnt", 32'(rel_cnt[0]), 32'd1);

    // Bounce on channel 1: toggling every 3 clk never gives 3 equal samples in a row.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k % 3 == 0) btn_raw[1] = ~btn_raw[1];
    end
    check_eq("c_no_press_bounce", 32'(press_cnt[1]), 32'd1);
    btn_raw[1] = 1'b1;
    wait_ticks(6);
    check_eq("c_press_cnt", 32'(press_cnt[1]), 32'd2);
    check_eq("c_level", 32'(btn_level_o[1]), 32'd1);

    // Short release glitch on channel 0, then a real release.
    align();
    btn_raw[0] = 1'b0;
    wait_ticks(2);
    align();
    btn_raw[0] = 1'b1;
    wait_ticks(5);
    check_eq("d_glitch_rel_cnt", 32'(rel_cnt[0]), 32'd1);
    check_eq("d_glitch_level", 32'(btn_level_o[0]), 32'd1);
    check_eq("d_glitch_press_cnt", 32'(press_cnt[0]), 32'd2);
    align();
    btn_raw[0] = 1'b0;
    wait_pulse(0, 1'b1, r);
    check_eq("d_rel_latency", 32'(r), 32'd4);
    check_eq("d_level_at_rel", 32'(btn_level_o[0]), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("d_rel_cnt", 32'(rel_cnt[0]), 32'd2);

    // Simultaneous press on channels 0, 2, 4.
    btn_raw = '0;
    wait_ticks(6);
    check_eq("e_ch1_rel_cnt", 32'(rel_cnt[1]), 32'd2);
    align();
    btn_raw = 5'b10101;
    wait_pulse(0, 1'b0, r);
    check_eq("e_press_vec", 32'(btn_press_o), 32'h15);
    check_eq("e_latency", 32'(r), 32'd4);
    wait_ticks(1);
    check_eq("e_press_cnt0", 32'(press_cnt[0]), 32'd3);
    check_eq("e_press_cnt2", 32'(press_cnt[2]), 32'd2);
    check_eq("e_press_cnt4", 32'(press_cnt[4]), 32'd2);

    // Reset while channel 2 is three samples into a press.
    btn_raw = '0;
    wait_ticks(6);
    check_eq("f_idle_level", 32'(btn_level_o), 32'h0);
    align();
    btn_raw = 5'b00100;
    wait_ticks(3);
    check_eq("f_no_press_yet", 32'(press_cnt[2]), 32'd2);
    check_eq("f_level_pre", 32'(btn_level_o[2]), 32'd0);
    align();
    rst = 1'b1;
    @(negedge clk);
    check_eq("f_rst_level", 32'(btn_level_o), 32'h0);
    check_eq("f_rst_press", 32'(btn_press_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(2, 1'b0, r);
    check_eq("f_latency", 32'(r), 32'd4);
    repeat (3) @(negedge clk);
    check_eq("f_press_cnt", 32'(press_cnt[2]), 32'd3);

    check_eq("level_vs_pulse", 32'(bad_lvl), 32'd0);
    check_eq("press_and_release", 32'(bad_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
